// File: rtl/image_frame_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | image_frame_writer: captures a raster pixel stream into a 64x64 store.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module image_frame_writer #(
   parameter int DATA_W = 13,
   parameter int ADDR_W = 12,
   parameter int WIDTH  = 64,
   parameter int HEIGHT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              overrun,
   output logic [5:0]        cur_x,
   output logic [5:0]        cur_y
);

   localparam int                DEPTH     = WIDTH * HEIGHT;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] addr, addr_next;
   logic              overrun_next;
   logic              wr_en;
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         addr    <= '0;
         overrun <= 1'b0;
      end else begin
         state   <= state_next;
         addr    <= addr_next;
         overrun <= overrun_next;
      end
   end

   always_comb begin
      state_next   = state;
      addr_next    = addr;
      overrun_next = overrun;
      wr_en        = 1'b0;
      in_ready     = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_next = S_CAPTURE;
               addr_next  = '0;
            end
         end
         S_CAPTURE: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            // A restart takes priority: the coincident beat is dropped.
            if (start) begin
               addr_next = '0;
            end else if (in_valid) begin
               wr_en = 1'b1;
               if (addr == LAST_ADDR) begin
                  addr_next  = '0;
                  state_next = S_DONE;
               end else begin
                  addr_next = addr + ADDR_W'(1);
               end
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               state_next   = S_CAPTURE;
               addr_next    = '0;
               overrun_next = 1'b0;
            end else if (in_valid) begin
               overrun_next = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= in_data;
      end
   end

   // Read-before-write: a same-address write returns the old word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

   assign cur_x = addr[5:0];
   assign cur_y = addr[11:6];

endmodule
`default_nettype wire

// File: tb/tb_image_frame_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_image_frame_writer: scoreboard bench with a frame-level model.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_image_frame_writer;

   localparam int N = 4096;

   logic        clk = 1'b0;
   logic        rst_n, start, in_valid;
   logic [12:0] in_data;
   logic [11:0] rd_addr;
   logic        in_ready, busy, done, overrun;
   logic [12:0] rd_data;
   logic [5:0]  cur_x, cur_y;

   always #5 clk = ~clk;

   image_frame_writer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .busy     (busy),
      .done     (done),
      .overrun  (overrun),
      .cur_x    (cur_x),
      .cur_y    (cur_y)
   );

   int ncheck = 0;
   int nerr   = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      bit          rdy, bsy, dn, ovr;
      logic [5:0]  cx, cy;
      bit          rd_chk;
      logic [12:0] rd;
   } exp_t;

   exp_t q[$];

   // Frame-level reference: capture flag, done flag, sticky overrun, next index.
   bit          m_cap, m_done, m_ovr;
   int          m_ptr;
   logic [12:0] m_mem   [N];
   bit          m_known [N];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      ncheck++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic model_reset();
      m_cap  = 1'b0;
      m_done = 1'b0;
      m_ovr  = 1'b0;
      m_ptr  = 0;
   endtask

   // Drive one clock worth of inputs and queue what the outputs must show after it.
   task automatic cycle(input bit s, input bit v, input logic [12:0] d, input logic [11:0] ra);
      exp_t e;
      @(posedge clk);
      #1;
      start    = s;
      in_valid = v;
      in_data  = d;
      rd_addr  = ra;
      e.due    = cyc + 1;
      e.rd_chk = m_known[ra];
      e.rd     = m_mem[ra];
      if (s) begin
         m_cap  = 1'b1;
         m_done = 1'b0;
         m_ovr  = 1'b0;
         m_ptr  = 0;
      end else if (m_cap && v) begin
         m_mem[m_ptr]   = d;
         m_known[m_ptr] = 1'b1;
         m_ptr++;
         if (m_ptr == N) begin
            m_ptr  = 0;
            m_cap  = 1'b0;
            m_done = 1'b1;
         end
      end else if (m_done && v) begin
         m_ovr = 1'b1;
      end
      e.rdy = m_cap;
      e.bsy = m_cap;
      e.dn  = m_done;
      e.ovr = m_ovr;
      e.cx  = 6'(m_ptr % 64);
      e.cy  = 6'(m_ptr / 64);
      q.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'(0));
      chk({tag, "_busy"},     32'(busy),     32'(0));
      chk({tag, "_done"},     32'(done),     32'(0));
      chk({tag, "_overrun"},  32'(overrun),  32'(0));
      chk({tag, "_cur_x"},    32'(cur_x),    32'(0));
      chk({tag, "_cur_y"},    32'(cur_y),    32'(0));
      chk({tag, "_rd_data"},  32'(rd_data),  32'(0));
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         mon_e = q.pop_front();
         chk("sample_cycle", 32'(cyc),      32'(mon_e.due));
         chk("in_ready",     32'(in_ready), 32'(mon_e.rdy));
         chk("busy",         32'(busy),     32'(mon_e.bsy));
         chk("done",         32'(done),     32'(mon_e.dn));
         chk("overrun",      32'(overrun),  32'(mon_e.ovr));
         chk("cur_x",        32'(cur_x),    32'(mon_e.cx));
         chk("cur_y",        32'(cur_y),    32'(mon_e.cy));
         if (mon_e.rd_chk) chk("rd_data", 32'(rd_data), 32'(mon_e.rd));
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: actual=timeout required=finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      rd_addr  = '0;
      model_reset();
      for (int i = 0; i < N; i++) m_known[i] = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;

      // in_valid while idle is ignored
      repeat (5) cycle(1'b0, 1'b1, 13'($urandom), 12'($urandom));

      // full frame, data = address, continuous valid
      cycle(1'b1, 1'b0, '0, '0);
      for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, 13'(i), 12'($urandom));
      cycle(1'b0, 1'b0, '0, 12'h000);
      cycle(1'b0, 1'b0, '0, 12'h03F);
      cycle(1'b0, 1'b0, '0, 12'h040);
      cycle(1'b0, 1'b0, '0, 12'hFFF);

      // overrun in DONE, then re-arm
      repeat (3) cycle(1'b0, 1'b1, 13'h1ABC, 12'h000);
      cycle(1'b0, 1'b0, '0, 12'h000);
      cycle(1'b1, 1'b0, '0, 12'h000);

      // valid toggled every cycle
      for (int i = 0; i < 2 * N; i++)
         cycle(1'b0, (i % 2) == 0, 13'($urandom), 12'($urandom));

      // restart mid-frame, then a constant frame read back in full
      cycle(1'b1, 1'b0, '0, '0);
      for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 13'($urandom), 12'($urandom));
      cycle(1'b1, 1'b1, 13'h1FFF, '0);
      for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, 13'h0155, 12'($urandom));
      for (int a = 0; a < N; a++) cycle(1'b0, 1'b0, '0, 12'(a));

      // read-during-write at address 5
      cycle(1'b1, 1'b0, '0, '0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 13'($urandom), '0);
      cycle(1'b0, 1'b1, 13'h0123, '0);
      cycle(1'b1, 1'b0, '0, '0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 13'($urandom), '0);
      cycle(1'b0, 1'b1, 13'h0AAA, 12'd5);
      cycle(1'b0, 1'b0, '0, 12'd5);
      cycle(1'b0, 1'b0, '0, 12'd0);

      // random traffic with occasional restarts
      cycle(1'b1, 1'b0, '0, '0);
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
               13'($urandom), 12'($urandom));

      // asynchronous reset mid-capture
      cycle(1'b1, 1'b0, '0, '0);
      for (int i = 0; i < 2000; i++) cycle(1'b0, 1'b1, 13'($urandom), 12'($urandom));
      @(posedge clk);
      @(negedge clk);
      #2;
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, 1'b0, '0, 12'd1999);
      cycle(1'b0, 1'b1, 13'($urandom), 12'd1999);
      cycle(1'b1, 1'b0, '0, '0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 13'($urandom), 12'd1999);
      cycle(1'b0, 1'b0, '0, 12'd0);

      @(posedge clk);
      repeat (2) @(negedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", ncheck, nerr);
      $finish;
   end

endmodule
`default_nettype wire
